freq_input_refill: RTL and testbench

- Upstream feeder of the multi-channel two-entry input buffer in the freq sorter.
- Keeps per-channel slot credits and issues round-robin fetch requests to the memory reader for channels with a free slot.
- Registers returning records onto the buffer's enq/enq_idx/din port.
- Guarantees the buffer is never over-filled.

---
 rtl/freq_input_refill.sv | 144 ++++++++++++++
 tb/tb_freq_input_refill.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/freq_input_refill.sv
// Credit-based refill front end for the freq sorter's two-entry input buffer:
// round-robin fetch requests per channel with free slots, registered response forwarding.
module freq_input_refill #(
    parameter int unsigned C_LOG      = 5,
    parameter int unsigned FIFO_WIDTH = 1024,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [(1<<C_LOG)-1:0]   ch_en,
    output logic                    req_valid,
    output logic [C_LOG-1:0]        req_idx,
    input  logic                    req_ready,
    input  logic                    rsp_valid,
    input  logic [C_LOG-1:0]        rsp_idx,
    input  logic [FIFO_WIDTH-1:0]   rsp_data,
    output logic                    enq,
    output logic [C_LOG-1:0]        enq_idx,
    output logic [FIFO_WIDTH-1:0]   din,
    input  logic                    deq,
    input  logic [C_LOG-1:0]        deq_idx,
    input  logic [(1<<C_LOG)-1:0]   rdy,
    output logic                    err
);

    localparam int unsigned N    = 1 << C_LOG;
    localparam logic [1:0]  CMAX = 2'(DEPTH);

    logic [N-1:0][1:0]   r_credit;
    logic [C_LOG-1:0]    r_rr_ptr;
    logic                r_req_valid;
    logic [C_LOG-1:0]    r_req_idx;
    logic                r_enq;
    logic [C_LOG-1:0]    r_enq_idx;
    logic [FIFO_WIDTH-1:0] r_din;
    logic                r_err;

    logic [N-1:0]        w_cand;
    logic                w_arb_en;
    logic                w_found;
    logic [C_LOG-1:0]    w_pick;
    logic [C_LOG-1:0]    w_scan;
    logic                w_issue;
    logic [N-1:0]        w_dec;
    logic [N-1:0]        w_inc;
    logic                w_deq_err;
    logic                w_rsp_err;

    // A pending request holds its slot until accepted; the arbiter may refill it on the accepting edge.
    assign w_arb_en = !r_req_valid || req_ready;
    assign w_issue  = w_arb_en && w_found;

    always_comb begin
        w_cand = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_cand[i] = ch_en[i] && (r_credit[i] != 2'd0);
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_scan = r_rr_ptr + k[C_LOG-1:0];
            if (!w_found && w_cand[w_scan]) begin
                w_found = 1'b1;
                w_pick  = w_scan;
            end
        end
    end

    always_comb begin
        w_dec = '0;
        w_inc = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_dec[i] = w_issue && (w_pick == C_LOG'(i));
            w_inc[i] = deq && (deq_idx == C_LOG'(i));
        end
    end

    assign w_deq_err = deq && !w_dec[deq_idx] && (r_credit[deq_idx] == CMAX);
    assign w_rsp_err = rsp_valid && !rdy[rsp_idx];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_credit[i] <= CMAX;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (w_dec[i] && !w_inc[i]) begin
                    r_credit[i] <= r_credit[i] - 2'd1;
                end else if (w_inc[i] && !w_dec[i] && (r_credit[i] != CMAX)) begin
                    r_credit[i] <= r_credit[i] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_req_valid <= 1'b0;
            r_req_idx   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_arb_en) begin
            r_req_valid <= w_found;
            if (w_found) begin
                r_req_idx <= w_pick;
                r_rr_ptr  <= w_pick + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_enq     <= 1'b0;
            r_enq_idx <= '0;
            r_din     <= '0;
        end else begin
            r_enq <= rsp_valid;
            if (rsp_valid) begin
                r_enq_idx <= rsp_idx;
                r_din     <= rsp_data;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_deq_err || w_rsp_err) begin
            r_err <= 1'b1;
        end
    end

    assign req_valid = r_req_valid;
    assign req_idx   = r_req_idx;
    assign enq       = r_enq;
    assign enq_idx   = r_enq_idx;
    assign din       = r_din;
    assign err       = r_err;

endmodule

// File: tb/tb_freq_input_refill.sv
// Directed bench for freq_input_refill: reset, single channel, round robin,
// backpressure, response forwarding and protocol-violation flag.
module tb_freq_input_refill;

    localparam int unsigned C_LOG = 5;
    localparam int unsigned N     = 1 << C_LOG;
    localparam int unsigned FW    = 1024;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    ch_en;
    logic            req_valid;
    logic [C_LOG-1:0] req_idx;
    logic            req_ready;
    logic            rsp_valid;
    logic [C_LOG-1:0] rsp_idx;
    logic [FW-1:0]   rsp_data;
    logic            enq;
    logic [C_LOG-1:0] enq_idx;
    logic [FW-1:0]   din;
    logic            deq;
    logic [C_LOG-1:0] deq_idx;
    logic [N-1:0]    rdy;
    logic            err;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] pat;

    freq_input_refill #(.C_LOG(C_LOG), .FIFO_WIDTH(FW), .DEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .ch_en(ch_en),
        .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_data(rsp_data),
        .enq(enq), .enq_idx(enq_idx), .din(din),
        .deq(deq), .deq_idx(deq_idx), .rdy(rdy), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        ch_en = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_idx = '0;
        rsp_data = '0; deq = 1'b0; deq_idx = '0; rdy = '1;
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        pat = {128{8'hA5}};
        do_reset();

        // reset state
        check("rst_req_valid", FW'(req_valid), FW'(0));
        check("rst_req_idx", FW'(req_idx), FW'(0));
        check("rst_enq", FW'(enq), FW'(0));
        check("rst_din", din, '0);
        check("rst_err", FW'(err), FW'(0));
        step();
        step();
        check("idle_req_valid", FW'(req_valid), FW'(0));

        // single channel 3: two issues then out of credit
        ch_en = 32'h8; req_ready = 1'b1;
        step();
        check("sc_v0", FW'(req_valid), FW'(1));
        check("sc_i0", FW'(req_idx), FW'(3));
        step();
        check("sc_v1", FW'(req_valid), FW'(1));
        check("sc_i1", FW'(req_idx), FW'(3));
        step();
        check("sc_v2", FW'(req_valid), FW'(0));
        deq = 1'b1; deq_idx = 5'd3;
        step();
        deq = 1'b0;
        check("sc_t1", FW'(req_valid), FW'(0));
        step();
        check("sc_t2_v", FW'(req_valid), FW'(1));
        check("sc_t2_i", FW'(req_idx), FW'(3));
        step();
        check("sc_t3_v", FW'(req_valid), FW'(0));
        check("sc_err", FW'(err), FW'(0));

        // async reset mid-stream with a pending request
        ch_en = '1; req_ready = 1'b0;
        step();
        check("pre_rst_v", FW'(req_valid), FW'(1));
        #2;
        RST = 1'b1;
        #1;
        check("async_req_valid", FW'(req_valid), FW'(0));
        check("async_req_idx", FW'(req_idx), FW'(0));
        step();
        RST = 1'b0; ch_en = '0;
        step();
        step();
        check("post_rst_v", FW'(req_valid), FW'(0));

        // backpressure
        do_reset();
        ch_en = '1; req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_v", FW'(req_valid), FW'(1));
            check("bp_i", FW'(req_idx), FW'(0));
        end
        check("bp_credit0", FW'(dut.r_credit[0]), FW'(1));
        req_ready = 1'b1;
        step();
        check("bp_rel_v", FW'(req_valid), FW'(1));
        check("bp_rel_i", FW'(req_idx), FW'(1));

        // round robin over all channels, two passes
        do_reset();
        ch_en = '1; req_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            step();
            check("rr_v", FW'(req_valid), FW'(1));
            check("rr_i", FW'(req_idx), FW'(k % 32));
        end
        step();
        check("rr_end_v", FW'(req_valid), FW'(0));
        check("rr_ptr", FW'(dut.r_rr_ptr), FW'(0));

        // issue and deq on the same channel and edge
        do_reset();
        ch_en = 32'h8; req_ready = 1'b1; deq = 1'b1; deq_idx = 5'd3;
        step();
        deq = 1'b0; ch_en = '0;
        check("same_v", FW'(req_valid), FW'(1));
        check("same_credit3", FW'(dut.r_credit[3]), FW'(2));
        check("same_err", FW'(err), FW'(0));

        // response forwarding
        do_reset();
        rsp_valid = 1'b1; rsp_idx = 5'd5; rsp_data = pat;
        step();
        rsp_valid = 1'b0; rsp_data = '0;
        check("fw_enq", FW'(enq), FW'(1));
        check("fw_idx", FW'(enq_idx), FW'(5));
        check("fw_din", din, pat);
        check("fw_err", FW'(err), FW'(0));
        step();
        check("fw_enq_off", FW'(enq), FW'(0));
        check("fw_din_hold", din, pat);

        // deq at full credit
        do_reset();
        deq = 1'b1; deq_idx = 5'd7;
        step();
        deq = 1'b0;
        check("deq_err", FW'(err), FW'(1));
        check("deq_credit7", FW'(dut.r_credit[7]), FW'(2));

        // response into a full channel
        do_reset();
        check("err_cleared", FW'(err), FW'(0));
        rsp_valid = 1'b1; rsp_idx = 5'd9; rsp_data = pat; rdy = ~(32'h1 << 9);
        step();
        rsp_valid = 1'b0; rdy = '1;
        check("rsp_err", FW'(err), FW'(1));
        check("rsp_err_enq", FW'(enq), FW'(1));
        check("rsp_err_idx", FW'(enq_idx), FW'(9));
        step();
        step();
        check("err_sticky", FW'(err), FW'(1));
        do_reset();
        check("err_rst", FW'(err), FW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
